// File: rtl/ibex_mac_seq.sv
// ibex_mac_seq: issue-side sequencer for the combinational vector MAC.
// Accepts one TAPS-element dot-product job, streams one tap per cycle into the
// MAC operand/opcode interface, accumulates the returned signed products and
// presents the sum (raw and 8-bit saturated) on a valid/ready response port.
module ibex_mac_seq #(
    parameter int TAPS  = 9,
    parameter int ACC_W = 20,
    parameter int SHIFT = 0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [TAPS*8-1:0]   req_a_i,
    input  logic [TAPS*8-1:0]   req_b_i,
    output logic                resp_valid_o,
    input  logic                resp_ready_i,
    output logic [ACC_W-1:0]    resp_acc_o,
    output logic [7:0]          resp_sat_o,
    output logic [7:0]          mac_operand_a_o,
    output logic [7:0]          mac_operand_b_o,
    output logic [7:0]          mac_carry_in_o,
    output logic [3:0]          mac_operator_o,
    input  logic [15:0]         mac_result_i,
    output logic                busy_o
);

    localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-128);
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_NOP = 4'b0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_e;

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [CNT_W-1:0]        r_tap_cnt;
    logic signed [ACC_W-1:0] r_acc;
    logic [TAPS*8-1:0]       r_a;
    logic [TAPS*8-1:0]       r_b;

    logic                    w_accept;
    logic                    w_issue;
    logic [7:0]              w_tap_a;
    logic [7:0]              w_tap_b;
    logic signed [ACC_W-1:0] w_prod_ext;

    // Arithmetic shift then clamp into the signed 8-bit range.
    function automatic logic [7:0] sat8(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] t;
        t = v >>> SHIFT;
        if (t > SAT_HI) begin
            sat8 = 8'h7F;
        end else if (t < SAT_LO) begin
            sat8 = 8'h80;
        end else begin
            sat8 = t[7:0];
        end
    endfunction

    assign w_accept   = (r_state == S_IDLE) && req_valid_i;
    assign w_issue    = (r_state == S_ISSUE);
    // The MAC returns a signed 16-bit product; widen it before accumulating.
    assign w_prod_ext = {{(ACC_W-16){mac_result_i[15]}}, mac_result_i};

    assign mac_carry_in_o = 8'h00;
    assign resp_acc_o     = r_acc;
    assign resp_sat_o     = sat8(r_acc);

    // Select the latched operand bytes of the current tap.
    always_comb begin
        w_tap_a = 8'h00;
        w_tap_b = 8'h00;
        for (int k = 0; k < TAPS; k++) begin
            if (r_tap_cnt == CNT_W'(k)) begin
                w_tap_a = r_a[8*k +: 8];
                w_tap_b = r_b[8*k +: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded outputs; MAC opcode is a no-op outside ISSUE.
    always_comb begin
        w_state_nxt     = r_state;
        req_ready_o     = 1'b0;
        busy_o          = 1'b0;
        resp_valid_o    = 1'b0;
        mac_operand_a_o = 8'h00;
        mac_operand_b_o = 8'h00;
        mac_operator_o  = OP_NOP;
        case (r_state)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy_o          = 1'b1;
                mac_operand_a_o = w_tap_a;
                mac_operand_b_o = w_tap_b;
                mac_operator_o  = OP_MUL;
                if (r_tap_cnt == LAST_TAP) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                busy_o       = 1'b1;
                resp_valid_o = 1'b1;
                if (resp_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand latch, tap counter and accumulator; the accumulator holds its
    // final value through RESP so the response stays stable until taken.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_tap_cnt <= '0;
        end else if (w_accept) begin
            r_a       <= req_a_i;
            r_b       <= req_b_i;
            r_acc     <= '0;
            r_tap_cnt <= '0;
        end else if (w_issue) begin
            r_acc <= r_acc + w_prod_ext;
            if (r_tap_cnt == LAST_TAP) begin
                r_tap_cnt <= '0;
            end else begin
                r_tap_cnt <= r_tap_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ibex_mac_seq.sv
// Testbench for ibex_mac_seq: emulates the combinational MAC, drives directed
// and random dot-product jobs and compares against a plain-arithmetic model.
module tb_ibex_mac_seq;

    localparam int TAPS  = 9;
    localparam int ACC_W = 20;
    localparam int SHIFT = 0;

    logic                    clk = 1'b0;
    logic                    rst_ni = 1'b1;
    logic                    req_valid = 1'b0;
    logic                    resp_ready = 1'b0;
    logic [TAPS*8-1:0]       req_a = '0;
    logic [TAPS*8-1:0]       req_b = '0;
    logic                    req_ready;
    logic                    resp_valid;
    logic                    busy;
    logic signed [ACC_W-1:0] resp_acc;
    logic signed [7:0]       resp_sat;
    logic signed [7:0]       mac_a;
    logic signed [7:0]       mac_b;
    logic [7:0]              mac_cin;
    logic [3:0]              mac_op;
    logic [15:0]             mac_res;

    int n_vec = 0;
    int n_bad = 0;

    logic signed [7:0] ja [TAPS];
    logic signed [7:0] jb [TAPS];
    logic signed [7:0] na [TAPS];
    logic signed [7:0] nb [TAPS];

    ibex_mac_seq #(.TAPS(TAPS), .ACC_W(ACC_W), .SHIFT(SHIFT)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_a_i         (req_a),
        .req_b_i         (req_b),
        .resp_valid_o    (resp_valid),
        .resp_ready_i    (resp_ready),
        .resp_acc_o      (resp_acc),
        .resp_sat_o      (resp_sat),
        .mac_operand_a_o (mac_a),
        .mac_operand_b_o (mac_b),
        .mac_carry_in_o  (mac_cin),
        .mac_operator_o  (mac_op),
        .mac_result_i    (mac_res),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    // Combinational MAC: signed 8x8 multiply when the opcode asks for it.
    assign mac_res = (mac_op == 4'b0010) ? 16'(int'(mac_a) * int'(mac_b)) : 16'h0000;

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint model_acc();
        longint s;
        logic signed [ACC_W-1:0] w;
        s = 0;
        for (int k = 0; k < TAPS; k++) s += longint'(ja[k]) * longint'(jb[k]);
        w = ACC_W'(s);
        return longint'(w);
    endfunction

    function automatic longint model_sat(input longint acc);
        longint t;
        t = acc >>> SHIFT;
        if (t > 127) return 127;
        if (t < -128) return -128;
        return t;
    endfunction

    task automatic pack_cur();
        for (int k = 0; k < TAPS; k++) begin
            req_a[8*k +: 8] = ja[k];
            req_b[8*k +: 8] = jb[k];
        end
    endtask

    task automatic pack_next();
        for (int k = 0; k < TAPS; k++) begin
            req_a[8*k +: 8] = na[k];
            req_b[8*k +: 8] = nb[k];
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rvalid"}, longint'(resp_valid), 0);
        check({tag, "_acc"},    longint'(resp_acc), 0);
        check({tag, "_sat"},    longint'(resp_sat), 0);
        check({tag, "_mac_a"},  longint'(mac_a), 0);
        check({tag, "_mac_b"},  longint'(mac_b), 0);
        check({tag, "_cin"},    longint'(mac_cin), 0);
        check({tag, "_op"},     longint'(mac_op), 0);
        check({tag, "_busy"},   longint'(busy), 0);
        check({tag, "_ready"},  longint'(req_ready), 1);
    endtask

    // Runs one job from ja/jb; must be called just after a negedge.
    // hold: cycles with resp_ready low in RESP; hold_req: present na/nb as a
    // new request during RESP; abort_tap: pull reset while that tap is issued.
    task automatic run_job(input int hold, input bit hold_req, input int abort_tap);
        longint e_acc;
        longint e_sat;
        int     to;
        e_acc = model_acc();
        e_sat = model_sat(e_acc);
        pack_cur();
        req_valid = 1'b1;
        to = 0;
        while (!req_ready && to < 50) begin
            @(negedge clk);
            to++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < TAPS; k++) begin
            check($sformatf("tap%0d_mac_a", k), longint'(mac_a), longint'(ja[k]));
            check($sformatf("tap%0d_mac_b", k), longint'(mac_b), longint'(jb[k]));
            check($sformatf("tap%0d_op", k), longint'(mac_op), 2);
            check($sformatf("tap%0d_rvalid", k), longint'(resp_valid), 0);
            check($sformatf("tap%0d_ready", k), longint'(req_ready), 0);
            check($sformatf("tap%0d_busy", k), longint'(busy), 1);
            if (k == abort_tap) begin
                rst_ni = 1'b0;
                #1;
                check_reset_outputs("abort");
                @(negedge clk);
                rst_ni = 1'b1;
                for (int c = 0; c < TAPS + 2; c++) begin
                    @(negedge clk);
                    check("abort_no_resp", longint'(resp_valid), 0);
                end
                return;
            end
            @(negedge clk);
        end
        check("resp_valid", longint'(resp_valid), 1);
        check("resp_acc", longint'(resp_acc), e_acc);
        check("resp_sat", longint'(resp_sat), e_sat);
        check("resp_op", longint'(mac_op), 0);
        check("resp_mac_a", longint'(mac_a), 0);
        check("resp_mac_b", longint'(mac_b), 0);
        for (int h = 0; h < hold; h++) begin
            if (hold_req) begin
                pack_next();
                req_valid = 1'b1;
            end
            @(negedge clk);
            check("hold_rvalid", longint'(resp_valid), 1);
            check("hold_acc", longint'(resp_acc), e_acc);
            check("hold_sat", longint'(resp_sat), e_sat);
            check("hold_ready", longint'(req_ready), 0);
            check("hold_busy", longint'(busy), 1);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        check("post_rvalid", longint'(resp_valid), 0);
        check("post_ready", longint'(req_ready), 1);
        check("post_busy", longint'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);

        // All ones: sum 9.
        for (int k = 0; k < TAPS; k++) begin ja[k] = 8'sd1; jb[k] = 8'sd1; end
        check("t1_model", model_acc(), 9);
        run_job(0, 1'b0, -1);

        // Largest positive products: positive saturation.
        for (int k = 0; k < TAPS; k++) begin ja[k] = -8'sd128; jb[k] = -8'sd128; end
        run_job(1, 1'b0, -1);

        // Largest negative products: negative saturation.
        for (int k = 0; k < TAPS; k++) begin ja[k] = 8'sd127; jb[k] = -8'sd128; end
        run_job(2, 1'b0, -1);

        // Ramp operand: verifies issue order.
        for (int k = 0; k < TAPS; k++) begin ja[k] = 8'(k); jb[k] = 8'sd2; end
        run_job(0, 1'b0, -1);

        // Response back-pressure with a competing request held high.
        for (int k = 0; k < TAPS; k++) begin
            ja[k] = 8'($urandom); jb[k] = 8'($urandom);
            na[k] = 8'($urandom); nb[k] = 8'($urandom);
        end
        run_job(5, 1'b1, -1);
        for (int k = 0; k < TAPS; k++) begin ja[k] = na[k]; jb[k] = nb[k]; end
        run_job(0, 1'b0, -1);

        // Reset during tap 4, then a clean job.
        for (int k = 0; k < TAPS; k++) begin ja[k] = 8'sd50; jb[k] = 8'sd50; end
        run_job(0, 1'b0, 4);
        for (int k = 0; k < TAPS; k++) begin ja[k] = 8'sd1; jb[k] = 8'sd1; end
        run_job(0, 1'b0, -1);

        // Random jobs with random back-pressure.
        for (int j = 0; j < 25; j++) begin
            for (int k = 0; k < TAPS; k++) begin
                ja[k] = 8'($urandom); jb[k] = 8'($urandom);
            end
            run_job(int'($urandom_range(0, 3)), 1'b0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
